// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: constants, unpacked operand type, divider FSM states
// and operand classification helpers (subnormals are treated as zero).
package fp32_pkg;

  localparam logic [9:0]  FP32_BIAS    = 10'd127;
  localparam logic [9:0]  FP32_EXP_MAX = 10'd255;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP32_INF     = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
  } fp32_unpacked_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIVIDE = 3'd1,
    ST_NORM   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } div_state_e;

  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign = x[31];
    u.exp  = {2'b00, x[30:23]};
    u.mant = {(x[30:23] != 8'h00), x[22:0]};
    return u;
  endfunction

  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp32_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic fp32_is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

endpackage

// File: rtl/fp32_div_iter.sv
// Restoring radix-2 mantissa divider: 26 quotient bits, one per cycle, after a
// start strobe; o_done is high during the final iteration cycle.
module fp32_div_iter
  import fp32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [23:0] i_dividend,
  input  logic [23:0] i_divisor,
  output logic        o_done,
  output logic [25:0] o_q,
  output logic        o_sticky
);

  logic [24:0] r_rem;
  logic [23:0] r_div;
  logic [25:0] r_q;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        w_ge;
  logic [23:0] w_diff;

  // Trial subtraction; a difference always fits in 24 bits since it is below the divisor
  always_comb begin
    w_ge = (r_rem >= {1'b0, r_div});
    if (w_ge) begin
      w_diff = r_rem[23:0] - r_div;
    end else begin
      w_diff = r_rem[23:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem  <= 25'd0;
      r_div  <= 24'd0;
      r_q    <= 26'd0;
      r_cnt  <= 5'd0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= {1'b0, i_dividend};
      r_div  <= i_divisor;
      r_q    <= 26'd0;
      r_cnt  <= 5'd25;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= {w_diff, 1'b0};
      r_q   <= {r_q[24:0], w_ge};
      if (r_cnt == 5'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  assign o_done   = r_busy && (r_cnt == 5'd0);
  assign o_q      = r_q;
  assign o_sticky = (r_rem != 25'd0);

endmodule

// File: rtl/fp32_div.sv
// Iterative fp32 divider c = a / b with flush-to-zero and round-to-nearest-even.
// Optional macro FP32_DIV_FLAGS_EN adds flags_out = {invalid, div_by_zero, overflow, underflow}.
module fp32_div
  import fp32_pkg::*;
#(
  parameter bit EARLY_SPECIAL = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        valid_out,
  output logic [31:0] c_out
`ifdef FP32_DIV_FLAGS_EN
  ,
  output logic [3:0]  flags_out
`endif
);

  div_state_e     r_state, w_state_nxt;
  fp32_unpacked_t w_ua, w_ub;
  logic           w_sign, w_accept, w_iter_start, w_iter_done, w_iter_sticky;
  logic [25:0]    w_iter_q;
  logic           w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic           w_invalid, w_spec_hit;
  logic [31:0]    w_spec_val;
  logic           r_sign, r_special, r_guard, r_sticky, r_valid;
  logic [9:0]     r_exp;
  logic [22:0]    r_frac;
  logic [31:0]    r_spec_val, r_c;
  logic           w_round_up, w_ovf, w_unf;
  logic [23:0]    w_frac_inc;
  logic [22:0]    w_frac_fin;
  logic [9:0]     w_exp_fin;
  logic [31:0]    w_result;

  assign w_ua     = fp32_unpack(a_in);
  assign w_ub     = fp32_unpack(b_in);
  assign w_sign   = w_ua.sign ^ w_ub.sign;
  assign w_a_nan  = fp32_is_nan(a_in);
  assign w_a_inf  = fp32_is_inf(a_in);
  assign w_a_zero = fp32_is_zero(a_in);
  assign w_b_nan  = fp32_is_nan(b_in);
  assign w_b_inf  = fp32_is_inf(b_in);
  assign w_b_zero = fp32_is_zero(b_in);

  assign ready_out    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept     = valid_in && ready_out;
  assign w_iter_start = w_accept && !(EARLY_SPECIAL && w_spec_hit);

  // Special-operand result, highest priority first
  always_comb begin
    w_invalid  = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    w_spec_hit = 1'b1;
    w_spec_val = FP32_QNAN;
    if (w_invalid) begin
      w_spec_val = FP32_QNAN;
    end else if (w_a_inf || w_b_zero) begin
      w_spec_val = {w_sign, FP32_INF[30:0]};
    end else if (w_a_zero || w_b_inf) begin
      w_spec_val = {w_sign, 31'd0};
    end else begin
      w_spec_hit = 1'b0;
      w_spec_val = 32'd0;
    end
  end

  fp32_div_iter u_iter (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_start    (w_iter_start),
    .i_dividend (w_ua.mant),
    .i_divisor  (w_ub.mant),
    .o_done     (w_iter_done),
    .o_q        (w_iter_q),
    .o_sticky   (w_iter_sticky)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; DONE accepts a new operation exactly like IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = (EARLY_SPECIAL && w_spec_hit) ? ST_ROUND : ST_DIVIDE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (w_iter_done) begin
          w_state_nxt = ST_NORM;
        end else begin
          w_state_nxt = ST_DIVIDE;
        end
      end
      ST_NORM:  w_state_nxt = ST_ROUND;
      ST_ROUND: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Round to nearest even; a fraction carry-out bumps the exponent
  always_comb begin
    w_round_up = r_guard && (r_sticky || r_frac[0]);
    w_frac_inc = {1'b0, r_frac} + {23'd0, w_round_up};
    if (w_frac_inc[23]) begin
      w_frac_fin = 23'd0;
      w_exp_fin  = r_exp + 10'd1;
    end else begin
      w_frac_fin = w_frac_inc[22:0];
      w_exp_fin  = r_exp;
    end
    w_ovf = $signed(w_exp_fin) >= $signed(FP32_EXP_MAX);
    w_unf = $signed(w_exp_fin) <= $signed(10'd0);
    if (r_special) begin
      w_result = r_spec_val;
    end else if (w_ovf) begin
      w_result = {r_sign, FP32_INF[30:0]};
    end else if (w_unf) begin
      w_result = {r_sign, 31'd0};
    end else begin
      w_result = {r_sign, w_exp_fin[7:0], w_frac_fin};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sign     <= 1'b0;
      r_exp      <= 10'd0;
      r_special  <= 1'b0;
      r_spec_val <= 32'd0;
      r_frac     <= 23'd0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_c        <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign     <= w_sign;
        r_exp      <= w_ua.exp - w_ub.exp + FP32_BIAS;
        r_special  <= w_spec_hit;
        r_spec_val <= w_spec_val;
      end else if (r_state == ST_NORM) begin
        if (w_iter_q[25]) begin
          r_frac   <= w_iter_q[24:2];
          r_guard  <= w_iter_q[1];
          r_sticky <= w_iter_sticky | w_iter_q[0];
        end else begin
          r_frac   <= w_iter_q[23:1];
          r_guard  <= w_iter_q[0];
          r_sticky <= w_iter_sticky;
          r_exp    <= r_exp - 10'd1;
        end
      end
      if (r_state == ST_ROUND) begin
        r_c <= w_result;
      end
      r_valid <= (r_state == ST_ROUND);
    end
  end

  assign valid_out = r_valid;
  assign c_out     = r_c;

`ifdef FP32_DIV_FLAGS_EN
  logic       w_dbz;
  logic [3:0] w_flags, r_spec_flags, r_flags;

  assign w_dbz = w_b_zero && !w_a_zero && !w_a_inf && !w_a_nan;

  always_comb begin
    if (r_special) begin
      w_flags = r_spec_flags;
    end else if (w_ovf) begin
      w_flags = 4'b0010;
    end else if (w_unf) begin
      w_flags = 4'b0001;
    end else begin
      w_flags = 4'b0000;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_spec_flags <= 4'd0;
      r_flags      <= 4'd0;
    end else begin
      if (w_accept) begin
        r_spec_flags <= {w_invalid, w_dbz, 2'b00};
      end
      if (r_state == ST_ROUND) begin
        r_flags <= w_flags;
      end
    end
  end

  assign flags_out = r_flags;
`endif

endmodule

// File: tb/tb_fp32_div.sv
// Scoreboard bench for fp32_div: the driver queues expected results at accept,
// a negedge monitor pops and checks value, flags and 28-cycle latency.
module tb_fp32_div;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] a_in     = 32'd0;
  logic [31:0] b_in     = 32'd0;
  logic        ready_out, valid_out;
  logic [31:0] c_out;
`ifdef FP32_DIV_FLAGS_EN
  logic [3:0]  flags_out;
`endif

  typedef struct {
    logic [31:0] c;
    logic [3:0]  f;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  localparam int LAT = 28;
  localparam int NV  = 9;
  localparam logic [31:0] VA [NV] = '{32'h3F800000, 32'h3F800000, 32'hBF800000,
                                      32'h00000000, 32'h7FC00001, 32'h3F800000,
                                      32'h7F000000, 32'h00800000, 32'hC0C00000};
  localparam logic [31:0] VB [NV] = '{32'h40400000, 32'h3F800000, 32'h00000000,
                                      32'h00000000, 32'h3F800000, 32'hFF800000,
                                      32'h3E800000, 32'h40000000, 32'h40000000};
  localparam logic [31:0] VC [NV] = '{32'h3EAAAAAB, 32'h3F800000, 32'hFF800000,
                                      32'h7FC00000, 32'h7FC00000, 32'h80000000,
                                      32'h7F800000, 32'h00000000, 32'hC0400000};
  localparam logic [3:0]  VF [NV] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b1000,
                                      4'b0000, 4'b0010, 4'b0001, 4'b0000};

  fp32_div dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .a_in      (a_in),
    .b_in      (b_in),
    .valid_out (valid_out),
    .c_out     (c_out)
`ifdef FP32_DIV_FLAGS_EN
    ,
    .flags_out (flags_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("stray_valid", {31'd0, valid_out}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("c_out", c_out, e.c);
          chk("latency", 32'(cyc - e.acc), 32'(LAT));
`ifdef FP32_DIV_FLAGS_EN
          chk("flags", {28'd0, flags_out}, {28'd0, e.f});
`endif
        end
      end
    end
  end

  // Holds valid_in high with random operands while busy, real operands once ready
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [3:0] f, input bit hold);
    exp_t e;
    bit   done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk_in);
      valid_in = 1'b1;
      if (ready_out === 1'b1) begin
        a_in  = a;
        b_in  = b;
        e.c   = c;
        e.f   = f;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        done  = 1'b1;
      end else begin
        a_in = $urandom;
        b_in = $urandom;
      end
    end
    if (!done) chk("accept_timeout", {31'd0, ready_out}, 32'd1);
    @(posedge clk_in);
    #1;
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk_in);
    @(negedge clk_in);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_c_out", c_out, 32'd0);
`ifdef FP32_DIV_FLAGS_EN
    chk("rst_flags", {28'd0, flags_out}, 32'd0);
`endif
    rst_in = 1'b0;

    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0);
    @(negedge clk_in);
    chk("ready_busy", {31'd0, ready_out}, 32'd0);
    drain();

    for (int i = 0; i < NV; i++) begin
      send(VA[i], VB[i], VC[i], VF[i], 1'b0);
      drain();
    end

    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b1);
    send(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 1'b0);
    drain();

    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0);
    repeat (10) @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("abort_valid", {31'd0, valid_out}, 32'd0);
    chk("abort_c_out", c_out, 32'd0);
    exp_q.delete();
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("abort_ready", {31'd0, ready_out}, 32'd1);
    repeat (40) @(negedge clk_in);

    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0);
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
